// File: rtl/iomem_arbiter.sv
// ============================================================================
//  Module      : iomem_arbiter
//  Description : Two-master round-robin arbiter with bus timeout for the
//                PicoRV32 iomem bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iomem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter int          TW       = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic [TW-1:0] c_CNT_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;

  logic          w_sel1;
  logic          w_req;
  logic          w_expired;
  logic [31:0]   w_rdata;

  assign w_sel1    = (r_state == ST_GNT1);
  assign w_req     = w_sel1 ? m1_valid : m0_valid;
  assign w_expired = (r_cnt == c_CNT_LAST);
  // A real slave response always takes precedence over the timeout.
  assign w_rdata   = s_ready ? s_rdata : ERR_DATA;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    s_valid     = 1'b0;
    s_wstrb     = 4'h0;
    s_addr      = 32'h0;
    s_wdata     = 32'h0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = 32'h0;
    m1_rdata    = 32'h0;
    timeout     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (m0_valid && m1_valid) begin
          w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        end else if (m0_valid) begin
          w_state_nxt = ST_GNT0;
        end else if (m1_valid) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!w_req) begin
          // Granted master withdrew its request: abandon without a response.
          w_state_nxt = ST_IDLE;
        end else begin
          s_valid = 1'b1;
          s_wstrb = w_sel1 ? m1_wstrb : m0_wstrb;
          s_addr  = w_sel1 ? m1_addr  : m0_addr;
          s_wdata = w_sel1 ? m1_wdata : m0_wdata;
          if (s_ready || w_expired) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = w_sel1;
            timeout     = !s_ready;
            if (w_sel1) begin
              m1_ready = 1'b1;
              m1_rdata = w_rdata;
            end else begin
              m0_ready = 1'b1;
              m0_rdata = w_rdata;
            end
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_iomem_arbiter.sv
// ============================================================================
//  Module      : tb_iomem_arbiter
//  Description : Randomized self-checking bench for iomem_arbiter against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iomem_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR     = 32'hDEADBEEF;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        timeout;

  always #5 ck = ~ck;

  iomem_arbiter #(.TIMEOUT(TIMEOUT), .TW(8), .ERR_DATA(ERR)) dut (
    .ck(ck), .rst(rst),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long it has waited, who went last.
  int owner = -1;
  int age   = 0;
  int last  = 1;
  int model_to = 0;
  int dut_to   = 0;

  // Master request generators and slave behaviour knobs.
  bit          pend[2];
  logic [3:0]  ws[2];
  logic [31:0] ad[2], wd[2];
  int          req_pct    = 0;
  bit          abandon_en = 1'b0;
  int          slave_mode = 0;  // 0 random, 1 never ready, 2 ready exactly at threshold

  task automatic drive_masters();
    m0_valid = pend[0]; m0_wstrb = ws[0]; m0_addr = ad[0]; m0_wdata = wd[0];
    m1_valid = pend[1]; m1_wstrb = ws[1]; m1_addr = ad[1]; m1_wdata = wd[1];
  endtask

  task automatic new_req(input int n);
    pend[n] = 1'b1;
    ws[n]   = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
    ad[n]   = 32'h6000_0000 | ($urandom & 32'h0000_FFFC);
    wd[n]   = $urandom;
  endtask

  task automatic step();
    bit          v[2];
    bit          e_sv, e_to;
    bit          e_r[2];
    logic [31:0] e_rd;
    int          nxt_owner, nxt_age, nxt_last;

    @(negedge ck);
    for (int n = 0; n < 2; n++) begin
      if (!pend[n] && ($urandom_range(99) < req_pct)) new_req(n);
      else if (pend[n] && abandon_en && ($urandom_range(199) == 0)) pend[n] = 1'b0;
    end
    drive_masters();
    case (slave_mode)
      0:       s_ready = 1'($urandom_range(1));
      1:       s_ready = 1'b0;
      default: s_ready = (owner >= 0) && (age == TIMEOUT - 1);
    endcase
    s_rdata = $urandom;
    #1;

    v[0] = m0_valid; v[1] = m1_valid;
    e_sv = 0; e_to = 0; e_r[0] = 0; e_r[1] = 0; e_rd = 32'h0;
    nxt_owner = owner; nxt_age = age; nxt_last = last;
    if (owner < 0) begin
      if (v[0] && v[1]) nxt_owner = (last == 0) ? 1 : 0;
      else if (v[0])    nxt_owner = 0;
      else if (v[1])    nxt_owner = 1;
      nxt_age = 0;
    end else if (!v[owner]) begin
      nxt_owner = -1;
    end else begin
      e_sv = 1;
      if (s_ready) begin
        e_r[owner] = 1; e_rd = s_rdata; nxt_last = owner; nxt_owner = -1;
      end else if (age == TIMEOUT - 1) begin
        e_r[owner] = 1; e_rd = ERR; e_to = 1; nxt_last = owner; nxt_owner = -1;
      end else begin
        nxt_age = age + 1;
      end
    end

    check("s_valid", 32'(s_valid), 32'(e_sv));
    if (e_sv) begin
      check("s_addr",  s_addr,           ad[owner]);
      check("s_wstrb", 32'(s_wstrb),     32'(ws[owner]));
      check("s_wdata", s_wdata,          wd[owner]);
    end
    check("m0_ready", 32'(m0_ready), 32'(e_r[0]));
    check("m1_ready", 32'(m1_ready), 32'(e_r[1]));
    check("timeout",  32'(timeout),  32'(e_to));
    if (e_r[0] || owner == 1) check("m0_rdata", m0_rdata, e_r[0] ? e_rd : 32'h0);
    if (e_r[1] || owner == 0) check("m1_rdata", m1_rdata, e_r[1] ? e_rd : 32'h0);
    if (timeout) dut_to++;
    if (e_to) model_to++;

    @(posedge ck);
    owner = nxt_owner; age = nxt_age; last = nxt_last;
    for (int n = 0; n < 2; n++) if (e_r[n]) pend[n] = 1'b0;
  endtask

  initial begin
    bit got1;
    pend[0] = 0; pend[1] = 0;
    ws[0] = 0; ws[1] = 0; ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0;

    repeat (3) @(negedge ck);
    check("rst_s_valid",  32'(s_valid),  32'h0);
    check("rst_m0_ready", 32'(m0_ready), 32'h0);
    check("rst_m1_ready", 32'(m1_ready), 32'h0);
    check("rst_timeout",  32'(timeout),  32'h0);
    check("rst_s_addr",   s_addr,        32'h0);
    check("rst_m0_rdata", m0_rdata,      32'h0);
    rst = 1'b1;

    // Both masters saturating: round-robin alternation.
    req_pct = 100; slave_mode = 0;
    repeat (60) step();

    // General random traffic including withdrawn requests.
    req_pct = 35; abandon_en = 1'b1;
    repeat (1500) step();
    abandon_en = 1'b0;

    // Hung slave: every access completes through the timeout.
    slave_mode = 1; req_pct = 50;
    repeat (250) step();

    // Slave responds exactly on the timeout cycle: normal completion wins.
    slave_mode = 2;
    repeat (250) step();

    slave_mode = 0;
    repeat (200) step();
    check("timeout_count", 32'(dut_to), 32'(model_to));

    // Reset in the middle of a master-1 grant.
    req_pct = 0; slave_mode = 1;
    while (owner >= 0 || pend[0] || pend[1]) begin
      if (total > 200000) break;
      pend[0] = 0; pend[1] = 0;
      step();
    end
    new_req(1);
    got1 = 0;
    for (int i = 0; i < 10 && !got1; i++) begin
      step();
      got1 = (owner == 1);
    end
    check("wait_grant1", 32'(got1), 32'h1);
    @(negedge ck);
    rst = 1'b0;
    #1;
    check("midrst_s_valid",  32'(s_valid),  32'h0);
    check("midrst_m1_ready", 32'(m1_ready), 32'h0);
    check("midrst_timeout",  32'(timeout),  32'h0);
    owner = -1; age = 0; last = 1;
    pend[0] = 0; pend[1] = 0;
    drive_masters();
    @(negedge ck);
    rst = 1'b1;

    // Simultaneous request after reset must go to master 0.
    new_req(0); new_req(1);
    slave_mode = 0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
